xgriscv_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit in EX, beside the single-cycle ALU.
//  The pipeline control issues a request and stalls on busy; this block returns one 32-bit result with a done pulse.

---
 rtl/xgriscv_muldiv_pkg.sv | 26 ++
 rtl/xgriscv_muldiv_addsub.sv | 18 +
 rtl/xgriscv_muldiv.sv | 172 +++++++++++++++++
 tb/tb_xgriscv_muldiv.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/xgriscv_muldiv_pkg.sv
// Shared widths, funct3 encodings and state codes for the RV32M multiply/divide unit.
package xgriscv_muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned ADD_W = XLEN + 1;

    localparam logic [2:0] MD_OP_MUL    = 3'b000;
    localparam logic [2:0] MD_OP_MULH   = 3'b001;
    localparam logic [2:0] MD_OP_MULHSU = 3'b010;
    localparam logic [2:0] MD_OP_MULHU  = 3'b011;
    localparam logic [2:0] MD_OP_DIV    = 3'b100;
    localparam logic [2:0] MD_OP_DIVU   = 3'b101;
    localparam logic [2:0] MD_OP_REM    = 3'b110;
    localparam logic [2:0] MD_OP_REMU   = 3'b111;

    localparam logic [1:0] MD_ST_IDLE  = 2'd0;
    localparam logic [1:0] MD_ST_CALC  = 2'd1;
    localparam logic [1:0] MD_ST_FIXUP = 2'd2;

    // Magnitude of an operand when it is interpreted as signed.
    function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/xgriscv_muldiv_addsub.sv
// Shared 33-bit adder/subtractor used by the multiply accumulate and the divide trial subtract.
module xgriscv_muldiv_addsub
    import xgriscv_muldiv_pkg::*;
(
    input  logic [ADD_W-1:0] x,
    input  logic [ADD_W-1:0] y,
    input  logic             sub,
    output logic [ADD_W-1:0] sum,
    output logic             carry
);

    logic [ADD_W:0] full;

    assign full  = {1'b0, x} + {1'b0, (sub ? ~y : y)} + (ADD_W+1)'(sub);
    assign sum   = full[ADD_W-1:0];
    assign carry = full[ADD_W];

endmodule

// File: rtl/xgriscv_muldiv.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps, then a two-cycle sign fixup.
module xgriscv_muldiv
    import xgriscv_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]        state, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   hi, hi_d, lo, lo_d, mcand, mcand_d;
    logic              neg_q, neg_q_d, neg_r, neg_r_d, fix_ph, fix_ph_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              busy_d, done_d;
    logic [XLEN-1:0]   result_d;

    logic [ADD_W-1:0]  add_x, add_y, add_sum;
    logic              add_carry;
    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [2*XLEN-1:0] prod_neg;

    // Divide feeds the shifted partial remainder; multiply feeds the high product word.
    assign add_x    = op_q[2] ? {hi, lo[XLEN-1]} : {1'b0, hi};
    assign add_y    = {1'b0, mcand};
    assign prod_neg = -{hi, lo};

    assign a_sgn = (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
                   (op == MD_OP_DIV) || (op == MD_OP_REM);
    assign b_sgn = (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
                   (op == MD_OP_DIV) || (op == MD_OP_REM);
    assign a_abs = md_abs(a, a_sgn);
    assign b_abs = md_abs(b, b_sgn);

    xgriscv_muldiv_addsub u_addsub (
        .x     (add_x),
        .y     (add_y),
        .sub   (op_q[2]),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= MD_ST_IDLE;
            op_q   <= 3'b000;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            fix_ph <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_d;
            op_q   <= op_d;
            hi     <= hi_d;
            lo     <= lo_d;
            mcand  <= mcand_d;
            neg_q  <= neg_q_d;
            neg_r  <= neg_r_d;
            fix_ph <= fix_ph_d;
            cnt    <= cnt_d;
            busy   <= busy_d;
            done   <= done_d;
            result <= result_d;
        end
    end

    always_comb begin
        state_d  = state;
        op_d     = op_q;
        hi_d     = hi;
        lo_d     = lo;
        mcand_d  = mcand;
        neg_q_d  = neg_q;
        neg_r_d  = neg_r;
        fix_ph_d = fix_ph;
        cnt_d    = cnt;
        done_d   = 1'b0;
        result_d = result;

        case (state)
            MD_ST_IDLE: begin
                if (start && !flush) begin
                    op_d     = op;
                    cnt_d    = CNT_W'(0);
                    fix_ph_d = 1'b0;
                    neg_q_d  = (a_sgn & a[XLEN-1]) ^ (b_sgn & b[XLEN-1]);
                    neg_r_d  = a_sgn & a[XLEN-1];
                    hi_d     = '0;
                    mcand_d  = op[2] ? b_abs : a_abs;
                    lo_d     = op[2] ? a_abs : b_abs;
                    state_d  = MD_ST_CALC;
                    // Architectural special cases bypass the iteration with fixed quotient/remainder.
                    if (op[2] && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '1;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = MD_ST_FIXUP;
                    end else if (op[2] && !op[0] && (a == {1'b1, (XLEN-1)'(0)}) && (b == '1)) begin
                        hi_d    = '0;
                        lo_d    = {1'b1, (XLEN-1)'(0)};
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = MD_ST_FIXUP;
                    end
                end
            end
            MD_ST_CALC: begin
                cnt_d = cnt + CNT_W'(1);
                if (op_q[2]) begin
                    if (add_carry) begin
                        hi_d = add_sum[XLEN-1:0];
                        lo_d = {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = {hi[XLEN-2:0], lo[XLEN-1]};
                        lo_d = {lo[XLEN-2:0], 1'b0};
                    end
                end else if (lo[0]) begin
                    {hi_d, lo_d} = {add_sum, lo[XLEN-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi, lo[XLEN-1:1]};
                end
                if (cnt == CNT_W'(XLEN-1)) begin
                    state_d  = MD_ST_FIXUP;
                    fix_ph_d = 1'b0;
                end
            end
            MD_ST_FIXUP: begin
                if (!fix_ph) begin
                    fix_ph_d = 1'b1;
                    if (!op_q[2]) begin
                        if (neg_q) {hi_d, lo_d} = prod_neg;
                    end else begin
                        if (neg_q) lo_d = -lo;
                        if (neg_r) hi_d = -hi;
                    end
                end else begin
                    fix_ph_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = MD_ST_IDLE;
                    result_d = ((op_q == MD_OP_MUL) || (op_q[2:1] == 2'b10)) ? lo : hi;
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase

        // Squash wins over everything; the held result stays untouched.
        if (flush) begin
            state_d  = MD_ST_IDLE;
            fix_ph_d = 1'b0;
            done_d   = 1'b0;
            result_d = result;
        end

        busy_d = (state_d != MD_ST_IDLE);
    end

endmodule

// File: tb/tb_xgriscv_muldiv.sv
// Directed bench for xgriscv_muldiv: vector table plus flush, back-to-back and reset sequences.
module tb_xgriscv_muldiv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xgriscv_muldiv dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          bsy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done, bounded.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 34};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35, 34};
        vecs[2]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 34};
        vecs[3]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 35, 34};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35, 34};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35, 34};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        35, 34};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         35, 34};
        vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 3,  2};
        vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         3,  2};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3,  2};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 3,  2};
        vecs[12] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 3,  2};
        vecs[13] = '{3'b111, 32'd9,         32'd0,         32'd9,         3,  2};
        vecs[14] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 34};
        vecs[15] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 35, 34};
        vecs[16] = '{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 35, 34};
        vecs[17] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 35, 34};
        vecs[18] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35, 34};
        vecs[19] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 34};

        rstn  = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", result,      32'd0);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bcnt);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].bsy));
        end

        // Flush mid-CALC, with an ignored start pulse while busy.
        @(negedge clk);
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat, bcnt);
        check("pre_flush_result", result, 32'hFFFF_FFEB);
        @(negedge clk);
        issue(3'b100, 32'd100, 32'd7);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1;
                op    = 3'b011;
                a     = 32'hFFFF_FFFF;
                b     = 32'hFFFF_FFFF;
            end
            if (i == 6) start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy",   32'(busy), 32'd0);
        check("flush_done",   32'(done), 32'd0);
        check("flush_result", result,    32'hFFFF_FFEB);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("flush_no_done", 32'(dcnt), 32'd0);

        // Fresh op after flush, with start pulses during busy that must be ignored.
        issue(3'b101, 32'd100, 32'd7);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = (i < 3);
            op    = 3'b000;
            a     = 32'd3;
            b     = 32'd3;
        end
        wait_done(lat, bcnt);
        check("fresh_result",  result,        32'd14);
        check("fresh_latency", 32'(lat + 3),  32'd35);

        // Back-to-back: second start issued in the done cycle of the first.
        @(negedge clk);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        check("b2b_first_result", result, 32'hFFFF_FFFE);
        check("b2b_first_done",   32'(done), 32'd1);
        issue(3'b111, 32'd100, 32'd7);
        check("b2b_accept_busy", 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        check("b2b_second_result",  result,   32'd2);
        check("b2b_second_latency", 32'(lat), 32'd35);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("arst_busy",   32'(busy), 32'd0);
        check("arst_done",   32'(done), 32'd0);
        check("arst_result", result,    32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("arst_quiet", 32'(dcnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
